// File: rtl/mod_mul_pkg.sv
// Shared widths, latency and helpers for the Barrett modular multiplier.
package mod_mul_pkg;

  localparam int unsigned DATA_SIZE_ARB = 14;
  localparam int unsigned MOD_MUL_LAT   = 4;

  localparam int unsigned CoefW = DATA_SIZE_ARB;
  localparam int unsigned MuW   = CoefW + 1;
  localparam int unsigned ProdW = 2 * CoefW;
  localparam int unsigned RedW  = CoefW + 2;
  localparam int unsigned RemW  = CoefW + 1;
  localparam int unsigned WideW = 2 * MuW;
  localparam int unsigned NumW  = 2 * CoefW + 1;

  typedef logic [CoefW-1:0] coef_t;
  typedef logic [MuW-1:0]   mu_t;
  typedef logic [ProdW-1:0] prod_t;
  typedef logic [RedW-1:0]  red_t;

  // floor(2^(2K) / q); q is assumed to lie in (2^(K-1), 2^K).
  function automatic mu_t calc_mu(input coef_t q);
    logic [NumW-1:0] num;
    num           = '0;
    num[NumW-1]   = 1'b1;
    return mu_t'(num / NumW'(q));
  endfunction

endpackage

// File: rtl/mod_mul_if.sv
// Operand/result handshake bundle between a producer and the modular multiplier.
interface mod_mul_if;
  import mod_mul_pkg::*;

  coef_t q;
  mu_t   mu;
  logic  in_valid;
  logic  in_ready;
  coef_t a;
  coef_t b;
  logic  out_valid;
  logic  out_ready;
  coef_t out;

  modport master (
    output q, mu, in_valid, a, b, out_ready,
    input  in_ready, out_valid, out
  );

  modport slave (
    input  q, mu, in_valid, a, b, out_ready,
    output in_ready, out_valid, out
  );

endinterface

// File: rtl/mod_csub.sv
// Conditional subtraction: y = (x >= q) ? x - q : x, truncated to the output width.
module mod_csub #(
  parameter int unsigned InW  = 16,
  parameter int unsigned OutW = 15
) (
  input  logic [InW-1:0]  x_i,
  input  logic [InW-1:0]  q_i,
  output logic [OutW-1:0] y_o
);

  always_comb begin
    y_o = (x_i >= q_i) ? OutW'(x_i - q_i) : OutW'(x_i);
  end

endmodule

// File: rtl/mod_mul.sv
// Four-stage Barrett modular multiplier with a single global stall (advance).
module mod_mul
  import mod_mul_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  mod_mul_if.slave  bus
);

  logic advance;

  logic  s1_v_q, s2_v_q, s3_v_q, out_v_q;
  prod_t s1_p_q, s2_p_q;
  mu_t   s2_qh_q;
  red_t  s3_r_q;
  coef_t out_q;

  logic [WideW-1:0] s2_prod;
  prod_t            qhq;
  logic [RemW-1:0]  r1;
  coef_t            r2;

  assign advance       = bus.out_ready | ~out_v_q;
  assign bus.in_ready  = advance;
  assign bus.out_valid = out_v_q;
  assign bus.out       = out_q;

  // Quotient estimate from the top K+1 bits of p.
  assign s2_prod = WideW'(s1_p_q[ProdW-1:CoefW-1]) * WideW'(bus.mu);
  assign qhq     = ProdW'(s2_qh_q) * ProdW'(bus.q);

  mod_csub #(
    .InW  (RedW),
    .OutW (RemW)
  ) u_csub0 (
    .x_i (s3_r_q),
    .q_i (RedW'(bus.q)),
    .y_o (r1)
  );

  mod_csub #(
    .InW  (RemW),
    .OutW (CoefW)
  ) u_csub1 (
    .x_i (r1),
    .q_i (RemW'(bus.q)),
    .y_o (r2)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_v_q  <= 1'b0;
      s2_v_q  <= 1'b0;
      s3_v_q  <= 1'b0;
      out_v_q <= 1'b0;
      out_q   <= '0;
    end else if (advance) begin
      s1_v_q  <= bus.in_valid;
      s2_v_q  <= s1_v_q;
      s3_v_q  <= s2_v_q;
      out_v_q <= s3_v_q;
      // Keep the last result visible across bubbles.
      if (s3_v_q) begin
        out_q <= r2;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      s1_p_q  <= ProdW'(bus.a) * ProdW'(bus.b);
      s2_p_q  <= s1_p_q;
      s2_qh_q <= MuW'(s2_prod >> (CoefW + 1));
      s3_r_q  <= RedW'(s2_p_q - qhq);
    end
  end

endmodule
